// File: rtl/mezclador_bandas_pkg.sv
// Shared types and constants for the three-band mixer: FSM encoding, default widths
// and the saturation limits of the default sample format.
package mezclador_bandas_pkg;

  localparam int unsigned W_DEF  = 25;
  localparam int unsigned WG_DEF = 10;
  localparam int unsigned FG_DEF = 8;

  localparam logic signed [W_DEF-1:0] SAT_MAX = {1'b0, {(W_DEF-1){1'b1}}};
  localparam logic signed [W_DEF-1:0] SAT_MIN = {1'b1, {(W_DEF-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MB   = 3'd1,
    ST_MM   = 3'd2,
    ST_MA   = 3'd3,
    ST_OUT  = 3'd4
  } estado_t;

endpackage

// File: rtl/redondeo_saturacion.sv
// Round-half-up and saturate a gain-stage accumulator back to the W-bit sample format.
// Purely combinational.
module redondeo_saturacion #(
  parameter int unsigned W  = 25,
  parameter int unsigned WG = 10,
  parameter int unsigned FG = 8
) (
  input  logic signed [W+WG+1:0] acc,
  output logic signed [W-1:0]    sat_c
);

  localparam int unsigned WA = W + WG + 2;

  // One guard bit above the accumulator so the rounding add never wraps.
  localparam logic signed [WA:0] HALF    = {{(WA+1-FG){1'b0}}, 1'b1, {(FG-1){1'b0}}};
  localparam logic signed [WA:0] MAX_EXT = {{(WA-W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [WA:0] MIN_EXT = {{(WA-W+2){1'b1}}, {(W-1){1'b0}}};

  logic signed [WA:0] sum_c;
  logic signed [WA:0] r_c;

  always_comb begin
    sum_c = (WA+1)'(acc) + HALF;
    r_c   = sum_c >>> FG;
    if (r_c > MAX_EXT) begin
      sat_c = MAX_EXT[W-1:0];
    end else if (r_c < MIN_EXT) begin
      sat_c = MIN_EXT[W-1:0];
    end else begin
      sat_c = r_c[W-1:0];
    end
  end

endmodule

// File: rtl/mezclador_bandas.sv
// Three-band mixer: y = Gb*ypb + Gm*ypm + Ga*ypa using one shared multiplier over
// three cycles, then round and saturate to the sample format.
module mezclador_bandas
  import mezclador_bandas_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned WG = WG_DEF,
  parameter int unsigned FG = FG_DEF
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 Enable,
  input  logic signed [W-1:0]  ypb,
  input  logic signed [W-1:0]  ypm,
  input  logic signed [W-1:0]  ypa,
  input  logic signed [WG-1:0] Gb,
  input  logic signed [WG-1:0] Gm,
  input  logic signed [WG-1:0] Ga,
  output logic signed [W-1:0]  y,
  output logic                 Valid,
  output logic                 Overrun
);

  localparam int unsigned WP = W + WG;
  localparam int unsigned WA = W + WG + 2;

  estado_t state_q, state_d;

  logic signed [W-1:0]  ypb_q, ypb_d;
  logic signed [W-1:0]  ypm_q, ypm_d;
  logic signed [W-1:0]  ypa_q, ypa_d;
  logic signed [WG-1:0] gb_q, gb_d;
  logic signed [WG-1:0] gm_q, gm_d;
  logic signed [WG-1:0] ga_q, ga_d;
  logic signed [WA-1:0] acc_q, acc_d;
  logic signed [W-1:0]  y_q, y_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;

  logic signed [WP-1:0] op_a_c;
  logic signed [WP-1:0] op_b_c;
  logic signed [WP-1:0] prod_c;
  logic signed [W-1:0]  sat_c;

  // Shared multiplier: operands selected by the current band state.
  always_comb begin
    op_a_c = '0;
    op_b_c = '0;
    case (state_q)
      ST_MB: begin
        op_a_c = WP'(ypb_q);
        op_b_c = WP'(gb_q);
      end
      ST_MM: begin
        op_a_c = WP'(ypm_q);
        op_b_c = WP'(gm_q);
      end
      ST_MA: begin
        op_a_c = WP'(ypa_q);
        op_b_c = WP'(ga_q);
      end
      default: ;
    endcase
    prod_c = op_a_c * op_b_c;
  end

  redondeo_saturacion #(
    .W  (W),
    .WG (WG),
    .FG (FG)
  ) u_redondeo_saturacion (
    .acc   (acc_q),
    .sat_c (sat_c)
  );

  always_comb begin
    state_d   = state_q;
    ypb_d     = ypb_q;
    ypm_d     = ypm_q;
    ypa_d     = ypa_q;
    gb_d      = gb_q;
    gm_d      = gm_q;
    ga_d      = ga_q;
    acc_d     = acc_q;
    y_d       = y_q;
    valid_d   = 1'b0;
    overrun_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Enable) begin
          ypb_d   = ypb;
          ypm_d   = ypm;
          ypa_d   = ypa;
          gb_d    = Gb;
          gm_d    = Gm;
          ga_d    = Ga;
          state_d = ST_MB;
        end
      end
      ST_MB: begin
        acc_d   = WA'(prod_c);
        state_d = ST_MM;
      end
      ST_MM: begin
        acc_d   = acc_q + WA'(prod_c);
        state_d = ST_MA;
      end
      ST_MA: begin
        acc_d   = acc_q + WA'(prod_c);
        state_d = ST_OUT;
      end
      ST_OUT: begin
        y_d     = sat_c;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A strobe in any busy state, including OUT, is dropped and flagged.
    if (Enable && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      ypb_q     <= '0;
      ypm_q     <= '0;
      ypa_q     <= '0;
      gb_q      <= '0;
      gm_q      <= '0;
      ga_q      <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ypb_q     <= ypb_d;
      ypm_q     <= ypm_d;
      ypa_q     <= ypa_d;
      gb_q      <= gb_d;
      gm_q      <= gm_d;
      ga_q      <= ga_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign y       = y_q;
  assign Valid   = valid_q;
  assign Overrun = overrun_q;

endmodule

// File: tb/tb_mezclador_bandas.sv
// Self-checking bench for mezclador_bandas: directed vector table, hand-written
// overrun/reset sequences, and randomized samples against an arithmetic model.
module tb_mezclador_bandas;

  logic               CLK;
  logic               Reset;
  logic               Enable;
  logic signed [24:0] ypb, ypm, ypa;
  logic signed [9:0]  Gb, Gm, Ga;
  logic signed [24:0] y;
  logic               Valid;
  logic               Overrun;

  int n_chk;
  int n_fail;

  mezclador_bandas dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .Enable  (Enable),
    .ypb     (ypb),
    .ypm     (ypm),
    .ypa     (ypa),
    .Gb      (Gb),
    .Gm      (Gm),
    .Ga      (Ga),
    .y       (y),
    .Valid   (Valid),
    .Overrun (Overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int b, m, a;
    int gb, gm, ga;
    int exp_y;
  } vec_t;

  vec_t tbl[12];

  // Reference: exact weighted sum, floor((acc + 0.5 LSB) / 2^8), clamp to 25-bit range.
  function automatic int model(input longint b, m, a, gb, gm, ga);
    longint acc;
    longint r;
    acc = b * gb + m * gm + a * ga;
    r = (acc + 64'sd128) >>> 8;
    if (r > 64'sd16777215) r = 64'sd16777215;
    if (r < -64'sd16777216) r = -64'sd16777216;
    return int'(r);
  endfunction

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic scramble();
    ypb = 25'($urandom);
    ypm = 25'($urandom);
    ypa = 25'($urandom);
    Gb  = 10'($urandom);
    Gm  = 10'($urandom);
    Ga  = 10'($urandom);
  endtask

  // Called just after a negedge; strobes one sample and checks the 4-edge latency.
  task automatic run_sample(input int b, m, a, gb, gm, ga, input int exp_y, input string tag);
    ypb = 25'(b);
    ypm = 25'(m);
    ypa = 25'(a);
    Gb  = 10'(gb);
    Gm  = 10'(gm);
    Ga  = 10'(ga);
    Enable = 1'b1;
    @(negedge CLK);
    Enable = 1'b0;
    scramble();
    for (int i = 1; i <= 4; i++) begin
      chk({tag, " valid_early"}, 64'(Valid), 64'sd0);
      chk({tag, " overrun"}, 64'(Overrun), 64'sd0);
      @(negedge CLK);
    end
    chk({tag, " valid"}, 64'(Valid), 64'sd1);
    chk({tag, " y"}, 64'(y), 64'(exp_y));
  endtask

  task automatic idle_check(input int cycles, input int exp_y, input string tag);
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      chk({tag, " valid_idle"}, 64'(Valid), 64'sd0);
      chk({tag, " y_hold"}, 64'(y), 64'(exp_y));
    end
  endtask

  initial begin
    int expa;
    int expb;
    n_chk  = 0;
    n_fail = 0;

    tbl[0]  = '{1000, 0, 0, 256, 256, 256, 1000};
    tbl[1]  = '{3, 3, 3, 128, 128, 128, 5};
    tbl[2]  = '{-3, 0, 0, 128, 128, 128, -1};
    tbl[3]  = '{16777215, 16777215, 16777215, 256, 256, 256, 16777215};
    tbl[4]  = '{-16777216, -16777216, -16777216, 256, 256, 256, -16777216};
    tbl[5]  = '{1, 0, 0, 128, 0, 0, 1};
    tbl[6]  = '{-1, 0, 0, 128, 0, 0, 0};
    tbl[7]  = '{12345, -999, 4242, 0, 0, 0, 0};
    tbl[8]  = '{100, 0, 0, -256, 0, 0, -100};
    tbl[9]  = '{0, 0, 5, 0, 0, -512, -10};
    tbl[10] = '{16777215, 0, 0, -512, 0, 0, -16777216};
    tbl[11] = '{-16777216, 0, 0, -512, 0, 0, 16777215};

    Reset  = 1'b0;
    Enable = 1'b0;
    ypb = '0; ypm = '0; ypa = '0;
    Gb  = '0; Gm  = '0; Ga  = '0;

    // Reset held for three cycles, then a quiet idle period.
    repeat (3) @(negedge CLK);
    chk("rst y", 64'(y), 64'sd0);
    chk("rst valid", 64'(Valid), 64'sd0);
    chk("rst overrun", 64'(Overrun), 64'sd0);
    Reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      scramble();
      @(negedge CLK);
      chk("idle y", 64'(y), 64'sd0);
      chk("idle valid", 64'(Valid), 64'sd0);
      chk("idle overrun", 64'(Overrun), 64'sd0);
    end

    for (int i = 0; i < 12; i++) begin
      run_sample(tbl[i].b, tbl[i].m, tbl[i].a, tbl[i].gb, tbl[i].gm, tbl[i].ga,
                 tbl[i].exp_y, $sformatf("vec%0d", i));
    end
    idle_check(1, tbl[11].exp_y, "after_tbl");

    // Randomized samples back to back at the maximum rate.
    for (int i = 0; i < 40; i++) begin
      logic signed [24:0] rb, rm, ra;
      logic signed [9:0]  gb, gm, ga;
      rb = 25'($urandom); rm = 25'($urandom); ra = 25'($urandom);
      gb = 10'($urandom); gm = 10'($urandom); ga = 10'($urandom);
      if (i % 4 == 0) begin
        rm = 25'($urandom_range(0, 2000)) - 25'sd1000;
        ra = 25'sd0;
      end
      run_sample(int'(rb), int'(rm), int'(ra), int'(gb), int'(gm), int'(ga),
                 model(rb, rm, ra, gb, gm, ga), $sformatf("rnd%0d", i));
    end

    // Second strobe two edges in is dropped; inputs change while the sample is in flight.
    expa = model(2000, -50, 9, 256, 300, -100);
    ypb = 25'sd2000; ypm = -25'sd50; ypa = 25'sd9;
    Gb = 10'sd256; Gm = 10'sd300; Ga = -10'sd100;
    Enable = 1'b1;
    @(negedge CLK);
    Enable = 1'b0;
    ypb = -25'sd12345; Gb = -10'sd7;
    chk("ovr5 overrun_k1", 64'(Overrun), 64'sd0);
    @(negedge CLK);
    Enable = 1'b1;
    @(negedge CLK);
    chk("ovr5 overrun_k2", 64'(Overrun), 64'sd1);
    chk("ovr5 valid_k2", 64'(Valid), 64'sd0);
    Enable = 1'b0;
    @(negedge CLK);
    chk("ovr5 overrun_k3", 64'(Overrun), 64'sd0);
    chk("ovr5 valid_k3", 64'(Valid), 64'sd0);
    @(negedge CLK);
    chk("ovr5 valid_k4", 64'(Valid), 64'sd1);
    chk("ovr5 y_k4", 64'(y), 64'(expa));
    idle_check(8, expa, "ovr5");

    // Strobe on the edge where OUT returns to IDLE is also dropped.
    expb = model(-4321, 777, 55555, -300, 128, 3);
    ypb = -25'sd4321; ypm = 25'sd777; ypa = 25'sd55555;
    Gb = -10'sd300; Gm = 10'sd128; Ga = 10'sd3;
    Enable = 1'b1;
    @(negedge CLK);
    Enable = 1'b0;
    repeat (3) @(negedge CLK);
    Enable = 1'b1;
    @(negedge CLK);
    Enable = 1'b0;
    chk("ovr_out valid", 64'(Valid), 64'sd1);
    chk("ovr_out y", 64'(y), 64'(expb));
    chk("ovr_out overrun", 64'(Overrun), 64'sd1);
    idle_check(8, expb, "ovr_out");

    // Reset asserted while the sample is in MM aborts it without a Valid.
    ypb = 25'sd5000; ypm = 25'sd6000; ypa = 25'sd7000;
    Gb = 10'sd256; Gm = 10'sd256; Ga = 10'sd256;
    Enable = 1'b1;
    @(negedge CLK);
    Enable = 1'b0;
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    chk("rst_mid y", 64'(y), 64'sd0);
    chk("rst_mid valid", 64'(Valid), 64'sd0);
    chk("rst_mid overrun", 64'(Overrun), 64'sd0);
    idle_check(2, 0, "rst_held");
    Reset = 1'b1;
    idle_check(6, 0, "rst_after");
    run_sample(7, 0, 0, 256, 0, 0, 7, "post_rst");
    idle_check(3, 7, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
